// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard / forwarding controller and the EX-stage operand mux.
package hazard_forward_ctrl_pkg;

    localparam int REG_W = 4;

    typedef logic [REG_W-1:0] reg_num_t;

    // EX operand mux select; 2'b11 is never produced.
    typedef enum logic [1:0] {
        SEL_REG = 2'b00,
        SEL_WB  = 2'b01,
        SEL_MEM = 2'b10
    } sel_t;

    typedef struct packed {
        logic     valid;
        reg_num_t src1;
        reg_num_t src2;
        logic     two_src;
        reg_num_t dest;
        logic     wb_en;
        logic     mem_r_en;
    } ex_entry_t;

    typedef struct packed {
        logic     valid;
        reg_num_t dest;
        logic     wb_en;
        logic     mem_r_en;
    } mem_entry_t;

    typedef struct packed {
        logic     valid;
        reg_num_t dest;
        logic     wb_en;
    } wb_entry_t;

    // True when a tracked instruction will write register r.
    function automatic logic writes_reg(input logic valid, input logic wb_en,
                                        input reg_num_t dest, input reg_num_t r);
        return valid & wb_en & (dest == r);
    endfunction

    // The MEM writer is younger than the WB writer, so it wins.
    function automatic sel_t pick_source(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return SEL_MEM;
        else if (wb_hit) return SEL_WB;
        else             return SEL_REG;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Decode/EX control bus between the pipeline (master) and the hazard unit (slave).
interface hazard_forward_ctrl_if;
    import hazard_forward_ctrl_pkg::*;

    logic     freeze;
    logic     id_valid;
    reg_num_t id_src1;
    reg_num_t id_src2;
    logic     id_two_src;
    reg_num_t id_dest;
    logic     id_wb_en;
    logic     id_mem_r_en;
    logic     branch_taken;
    logic     hazard_stall;
    logic     flush;
    sel_t     sel_src1;
    sel_t     sel_src2;

    modport master (
        output freeze, id_valid, id_src1, id_src2, id_two_src, id_dest,
               id_wb_en, id_mem_r_en, branch_taken,
        input  hazard_stall, flush, sel_src1, sel_src2
    );

    modport slave (
        input  freeze, id_valid, id_src1, id_src2, id_two_src, id_dest,
               id_wb_en, id_mem_r_en, branch_taken,
        output hazard_stall, flush, sel_src1, sel_src2
    );

endinterface

// File: rtl/hazard_track_entry.sv
// One registered pipeline-tracking entry with hold (freeze) and bubble control.
module hazard_track_entry #(
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   bubble,
    input  entry_t d,
    output entry_t q
);

    // Advance, hold or bubble the entry on every rising edge.
    always_ff @(posedge clk) begin
        // NOTE: rst is tested before hold so a reset clears the entry even while frozen.
        if (rst) begin
            q <= '0;
        end else if (!hold) begin
            // NOTE: non-blocking so each stage captures its upstream value from before this edge.
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// RAW hazard detection, load-use stall, branch flush and EX operand forwarding selects.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    hazard_forward_ctrl_if.slave bus
);

    ex_entry_t  ex_d, ex_q;
    mem_entry_t mem_d, mem_q;
    wb_entry_t  wb_d, wb_q;

    logic ex_bubble;
    logic ex_hit, mem_hit, raw_hazard;
    logic mem_src1_hit, mem_src2_hit, wb_src1_hit, wb_src2_hit;

    assign ex_d = '{valid:    bus.id_valid,
                    src1:     bus.id_src1,
                    src2:     bus.id_src2,
                    two_src:  bus.id_two_src,
                    dest:     bus.id_dest,
                    wb_en:    bus.id_wb_en,
                    mem_r_en: bus.id_mem_r_en};

    assign mem_d = '{valid:    ex_q.valid,
                     dest:     ex_q.dest,
                     wb_en:    ex_q.wb_en,
                     mem_r_en: ex_q.mem_r_en};

    assign wb_d = '{valid: mem_q.valid,
                    dest:  mem_q.dest,
                    wb_en: mem_q.wb_en};

    // A taken branch kills IF/ID and overrides any stall.
    assign bus.flush = bus.branch_taken;

    // A stalled, flushed or empty decode slot enters EX as a bubble.
    assign ex_bubble = ~bus.id_valid | bus.hazard_stall | bus.flush;

    hazard_track_entry #(.entry_t(ex_entry_t)) u_ex (
        .clk    (clk),
        .rst    (rst),
        .hold   (bus.freeze),
        .bubble (ex_bubble),
        .d      (ex_d),
        .q      (ex_q)
    );

    hazard_track_entry #(.entry_t(mem_entry_t)) u_mem (
        .clk    (clk),
        .rst    (rst),
        .hold   (bus.freeze),
        .bubble (1'b0),
        .d      (mem_d),
        .q      (mem_q)
    );

    hazard_track_entry #(.entry_t(wb_entry_t)) u_wb (
        .clk    (clk),
        .rst    (rst),
        .hold   (bus.freeze),
        .bubble (1'b0),
        .d      (wb_d),
        .q      (wb_q)
    );

    // Decode-side RAW detection against the older writers held in EX and MEM.
    always_comb begin
        ex_hit  = writes_reg(ex_q.valid, ex_q.wb_en, ex_q.dest, bus.id_src1)
                | (bus.id_two_src & writes_reg(ex_q.valid, ex_q.wb_en, ex_q.dest, bus.id_src2));
        mem_hit = writes_reg(mem_q.valid, mem_q.wb_en, mem_q.dest, bus.id_src1)
                | (bus.id_two_src & writes_reg(mem_q.valid, mem_q.wb_en, mem_q.dest, bus.id_src2));
        // With forwarding only a load in EX cannot be bypassed in time.
        if (FORWARD_EN) begin
            raw_hazard = ex_q.mem_r_en & ex_hit;
        end else begin
            raw_hazard = ex_hit | mem_hit;
        end
        bus.hazard_stall = bus.id_valid & raw_hazard & ~bus.branch_taken;
    end

    // EX operand mux selects, driven purely from the tracked entries.
    always_comb begin
        mem_src1_hit = writes_reg(mem_q.valid, mem_q.wb_en, mem_q.dest, ex_q.src1);
        mem_src2_hit = writes_reg(mem_q.valid, mem_q.wb_en, mem_q.dest, ex_q.src2);
        wb_src1_hit  = writes_reg(wb_q.valid, wb_q.wb_en, wb_q.dest, ex_q.src1);
        wb_src2_hit  = writes_reg(wb_q.valid, wb_q.wb_en, wb_q.dest, ex_q.src2);
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        bus.sel_src1 = SEL_REG;
        bus.sel_src2 = SEL_REG;
        if (FORWARD_EN && ex_q.valid) begin
            bus.sel_src1 = pick_source(mem_src1_hit, wb_src1_hit);
            if (ex_q.two_src) begin
                bus.sel_src2 = pick_source(mem_src2_hit, wb_src2_hit);
            end
        end
    end

    // A load still in MEM never feeds EX: the load-use stall keeps its consumer back a cycle.
    mem_load_not_forwarded: assert property (@(posedge clk) disable iff (rst)
        !(ex_q.valid && mem_q.mem_r_en &&
          (mem_src1_hit || (ex_q.two_src && mem_src2_hit))));

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 Parameter FORWARD_EN, default 1; 1 = forwarding plus load-use stall, 0 = no forwarding, stall on any RAW hazard.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 freeze  in  1  memory busy; holds all internal state when high.
REQ-005 id_valid  in  1  decode stage holds a real instruction.
REQ-006 id_src1, id_src2  in  4 each  decode source register numbers.
REQ-007 id_two_src  in  1  decode instruction reads id_src2.
REQ-008 id_dest  in  4  decode destination register.
REQ-009 id_wb_en, id_mem_r_en  in  1 each  decode writes a register / is a load.
REQ-010 branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-011 hazard_stall  out  1  hold PC and IF/ID registers.
REQ-012 flush  out  1  kill the IF/ID contents.
REQ-013 sel_src1, sel_src2  out  2 each  EX operand mux selects: 00 register value, 01 WB value, 10 MEM value; 11 never driven.

Function
REQ-014 Three internal tracking entries SHALL be kept: EX {valid, src1, src2, two_src, dest, wb_en, mem_r_en}, MEM {valid, dest, wb_en, mem_r_en}, WB {valid, dest, wb_en}.
REQ-015 When freeze=0, each rising edge SHALL advance EX→MEM→WB; WB's previous content is discarded.
REQ-016 When freeze=0, the EX entry SHALL load the decode fields if id_valid=1, hazard_stall=0 and flush=0; otherwise the EX entry SHALL load a bubble (valid=0).
REQ-017 When freeze=1, all entries SHALL hold, and every output SHALL be recomputed from the held entries and the current inputs.
REQ-018 flush SHALL equal branch_taken, combinationally.
REQ-019 match(E,r) SHALL be defined as E.valid & E.wb_en & (E.dest==r).
REQ-020 Source r SHALL be live if it is id_src1, or if it is id_src2 with id_two_src=1.
REQ-021 With FORWARD_EN=1, hazard_stall SHALL be id_valid & EX.mem_r_en & match(EX, live source).
REQ-022 With FORWARD_EN=0, hazard_stall SHALL be id_valid & (match(EX, live source) | match(MEM, live source)).
REQ-023 When flush=1, hazard_stall SHALL be forced to 0; flush has priority.
REQ-024 With FORWARD_EN=1, sel_src1 SHALL be 10 if match(MEM, EX.src1), else 01 if match(WB, EX.src1), else 00; MEM has priority as the younger writer.
REQ-025 sel_src2 SHALL follow the REQ-024 rule using EX.src2, but SHALL be 00 if EX.two_src=0.
REQ-026 A MEM-stage load SHALL never be selected; REQ-021 guarantees the consumer reaches EX only once the load is in WB.
REQ-027 sel_src1 and sel_src2 SHALL be 00 whenever EX.valid=0 or FORWARD_EN=0.
REQ-028 sel outputs SHALL depend only on internal entries; zero-cycle latency from the entries.

Reset
REQ-029 When rst=1 at a rising edge, all entries SHALL clear to valid=0 with all fields 0, overriding freeze.
REQ-030 After reset, hazard_stall=0, sel_src1=sel_src2=00, and flush follows branch_taken.
REQ-031 Reset asserted mid-stall SHALL drop the stall on the next cycle; no pending hazard survives.

Structure
REQ-032 Sel encodings (SEL_REG=00, SEL_WB=01, SEL_MEM=10) and the 4-bit register-number width SHALL reside in a shared package, also used by the EX-stage mux.
REQ-033 A single sub-module, hazard_track_entry (one registered stage entry with hold/bubble control), SHALL be instantiated three times; the compare and priority logic stays in the top module.

Verification
REQ-034 Back-to-back ALU dependency: ADD r1 then SUB r2,r1 → in SUB's EX cycle sel_src1=10, no stall.
REQ-035 Distance-2 dependency: ADD r3; NOP; ORR r4,r3 → sel_src1=01; with r3 also written by the middle instruction → sel_src1=10.
REQ-036 Load-use: LDR r5; ADD r6,r5 → hazard_stall=1 for exactly one cycle, bubble in EX, then sel_src1=01.
REQ-037 Load-use coinciding with branch_taken=1 → flush=1, hazard_stall=0, EX loads a bubble.
REQ-038 freeze=1 for 3 cycles during a forwarding case → sel outputs and entries held, then resume with identical values.
REQ-039 FORWARD_EN=0: ADD r7; ADD r8,r7 → hazard_stall=1 for 2 cycles, sel always 00; rst mid-stall → stall=0 the next cycle.
